// File: rtl/led_canvas_scan_if.sv
// Bundle between the mode controller / debouncers and the LED canvas.
// Master drives enable and button pulses; slave drives the matrix pins.
interface led_canvas_scan_if #(
    parameter int ROWS = 5,
    parameter int COLS = 7
);
    logic            en;
    logic            btn_mode;
    logic            btn_shift;
    logic            btn_dec;
    logic            btn_inc;
    logic            btn_toggle;
    logic            btn_clear;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] column;
    logic            edit;

    modport master (
        output en, btn_mode, btn_shift, btn_dec,
        output btn_inc, btn_toggle, btn_clear,
        input  row, column, edit
    );

    modport slave (
        input  en, btn_mode, btn_shift, btn_dec,
        input  btn_inc, btn_toggle, btn_clear,
        output row, column, edit
    );
endinterface

// File: rtl/led_canvas_scan.sv
// Row-scanned dot-matrix canvas with a frame buffer and a blinking
// edit cursor driven by one-cycle button pulses.
module led_canvas_scan #(
    parameter int ROWS      = 5,
    parameter int COLS      = 7,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_BIT = 24
) (
    input logic              CLOCK_50,
    input logic              rst,
    led_canvas_scan_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_BIT + 1;

    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);
    localparam logic [SW-1:0] S_TC  = SW'(SCAN_DIV - 1);

    typedef enum logic {
        VIEW = 1'b0,
        EDIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ROWS-1:0][COLS-1:0] fb;
    logic [RW-1:0]             cur_r;
    logic [CW-1:0]             cur_c;
    logic                      axis_row;
    logic [SW-1:0]             scan_cnt;
    logic [RW-1:0]             scan_idx;
    logic [BW-1:0]             blink_cnt;
    logic                      blink;
    logic                      act;
    logic                      mv_inc;
    logic                      mv_dec;
    logic [ROWS-1:0]           row_q, row_nxt;
    logic [COLS-1:0]           col_q, col_nxt;

    assign blink  = blink_cnt[BLINK_BIT];
    assign act    = bus.en && state == EDIT && !bus.btn_mode;
    assign mv_inc = act && bus.btn_inc && !bus.btn_dec;
    assign mv_dec = act && bus.btn_dec && !bus.btn_inc;

    // Mode state register; its value is the edit output.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state <= VIEW;
        else     state <= state_nxt;
    end

    // Mode toggling; losing enable always falls back to view.
    always_comb begin
        state_nxt = state;
        if (!bus.en)
            state_nxt = VIEW;
        else if (bus.btn_mode)
            state_nxt = (state == VIEW) ? EDIT : VIEW;
    end

    // Cursor axis and position; moves use the axis held before a shift.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            axis_row <= 1'b0;
            cur_r    <= '0;
            cur_c    <= '0;
        end else begin
            if (act && bus.btn_shift)
                axis_row <= ~axis_row;
            if (mv_inc) begin
                if (axis_row)
                    cur_r <= (cur_r == R_MAX) ? '0 : cur_r + RW'(1);
                else
                    cur_c <= (cur_c == C_MAX) ? '0 : cur_c + CW'(1);
            end else if (mv_dec) begin
                if (axis_row)
                    cur_r <= (cur_r == '0) ? R_MAX : cur_r - RW'(1);
                else
                    cur_c <= (cur_c == '0) ? C_MAX : cur_c - CW'(1);
            end
        end
    end

    // Frame buffer edits at the pre-move cursor; clear beats toggle.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            fb <= '0;
        else if (act && bus.btn_clear)
            fb <= '0;
        else if (act && bus.btn_toggle)
            fb[cur_r][cur_c] <= ~fb[cur_r][cur_c];
    end

    // Row dwell counter and scanned row index, independent of enable.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == S_TC) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == R_MAX) ? '0 : scan_idx + RW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Free-running counter whose top bit blinks the cursor.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) blink_cnt <= '0;
        else     blink_cnt <= blink_cnt + BW'(1);
    end

    // Pixels of the scanned row with the cursor overlaid.
    always_comb begin
        row_nxt = '0;
        col_nxt = '0;
        if (bus.en) begin
            row_nxt[scan_idx] = 1'b1;
            col_nxt = fb[scan_idx];
            if (state == EDIT && blink && cur_r == scan_idx)
                col_nxt[cur_c] = 1'b1;
        end
    end

    // Registered matrix drive.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_nxt;
            col_q <= col_nxt;
        end
    end

    assign bus.row    = row_q;
    assign bus.column = col_q;
    assign bus.edit   = (state == EDIT);
endmodule

// File: doc/led_canvas_scan.md
# led_canvas_scan

Parametrised, row-scanned dot-matrix canvas with cursor editing. It stores a ROWS×COLS bit frame buffer and drives one matrix row at a time, so any pixel pattern displays correctly rather than only row/column cross-points. In edit mode a blinking cursor is moved by button events, and pixels are set or cleared individually. It sits between the button_state debouncers and the LED matrix pins, selected by the top-level mode controller through `en`.

## Interface
- `ROWS`, 5, matrix rows (2..16)
- `COLS`, 7, matrix columns (2..16)
- `SCAN_DIV`, 50000, CLOCK_50 cycles each row stays active (≥2)
- `BLINK_BIT`, 24, free-running counter bit that gates cursor visibility

- `CLOCK_50` in 1: the only clock
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: block selected; 0 forces blank output and view mode
- `btn_mode` in 1: one-cycle pulse (key1 long press); toggles view/edit
- `btn_shift` in 1: one-cycle pulse (key1 short press); toggles the cursor axis between column and row
- `btn_dec` in 1: one-cycle pulse (key2 short press); moves the cursor in the negative direction
- `btn_inc` in 1: one-cycle pulse (key3 short press); moves the cursor in the positive direction
- `btn_toggle` in 1: one-cycle pulse (key4 short press); inverts the pixel under the cursor
- `btn_clear` in 1: one-cycle pulse (key4 long press); clears the whole frame buffer
- `row` out ROWS: one-hot row drive, active high
- `column` out COLS: column data for the active row, active high
- `edit` out 1: 1 while in edit mode

## Operation
- Reset: frame buffer all 0, `cur_r`=0, `cur_c`=0, axis=column, state VIEW, scan index 0, scan and blink counters 0. `row`, `column` and `edit` all reset to 0.
- Scan counter counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the scan index advances; index ROWS-1 wraps to 0. Both counters run regardless of `en`.
- Blink counter is BLINK_BIT+1 bits wide and free-running. `blink` is its MSB.
- Display pixel for (r,c) = fb[r][c] OR (edit & blink & r==`cur_r` & c==`cur_c`).
- `en`=1: `row` = one-hot of the scan index; `column` = display pixels of that row.
- `en`=0: `row`=0, `column`=0, state forced to VIEW, button pulses ignored. The frame buffer and cursor position are retained.
- FSM, state VIEW:
  - `btn_mode` → EDIT.
  - All other buttons are ignored.
- FSM, state EDIT:
  - `btn_mode` → VIEW.
  - `btn_shift` flips the axis.
  - `btn_inc` on the column axis: `cur_c`=COLS-1 wraps to 0, otherwise increments. The row axis behaves the same with ROWS.
  - `btn_dec` on the column axis: `cur_c`=0 wraps to COLS-1, otherwise decrements. The row axis behaves the same with ROWS.
  - `btn_toggle`: fb[`cur_r`][`cur_c`] is inverted.
  - `btn_clear`: all fb bits are set to 0.
- Simultaneous pulses in the same cycle (EDIT):
  - `btn_mode` wins; all others are dropped.
  - `btn_clear` beats `btn_toggle`.
  - `btn_toggle` acts on the pre-move cursor position; a move in the same cycle still applies.
  - `btn_inc` together with `btn_dec`: no move.
  - `btn_shift` together with a move: the move uses the old axis.
- Cursor index widths are $clog2(ROWS) and $clog2(COLS); the index never holds an out-of-range value.

## Timing
- All outputs are registered and change only on a CLOCK_50 rising edge, except the asynchronous clear on `rst`.
- A button pulse at edge N updates state, cursor and fb at edge N. The effect is visible on `row`/`column` at edge N+1 if that row is currently scanned; otherwise it appears at the next scan of that row.
- `edit` follows the state with 0 cycles of extra latency (it is the state register).
- Each row is active for exactly SCAN_DIV cycles. A full frame takes ROWS×SCAN_DIV cycles.
- `en` falling at edge N: outputs are 0 from edge N+1.
- `rst` asserted mid-scan or mid-edit: immediate return to the reset values, and the buffer is lost.

## Test plan
- Reset, `en`=1, SCAN_DIV=4, ROWS=5, COLS=7 → `row` cycles 00001,00010,…,10000,00001, each held 4 cycles; `column`=0 throughout; `edit`=0.
- Pulse `btn_mode`, then `btn_toggle` at (0,0), `btn_inc` ×2 (column axis), then `btn_toggle` → fb row0=0000101. With blink forced low, `column`=0000101 whenever `row`=00001 and 0 elsewhere.
- Column axis, `btn_dec` at `cur_c`=0 → `cur_c`=6. `btn_shift`, then `btn_inc` ×5 from `cur_r`=0 → `cur_r`=0 (wrap after 4).
- Same-cycle `btn_toggle`+`btn_inc` at (0,0) → fb[0][0]=1 and `cur_c`=1. Same-cycle `btn_mode`+`btn_clear` → state VIEW and fb unchanged.
- Drop `en` in EDIT with a drawn pattern → `row`/`column`=0 and `edit`=0 next cycle. Raise `en` again → same pattern displayed, state VIEW, cursor unchanged.
- Assert `rst` mid-frame in EDIT → all outputs 0 at once. After release, fb is empty and the cursor is at (0,0).
